alu_exec: RTL

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_exec.sv
// Multi-cycle ALU: ADD/SUB/AND/OR/XOR/SHL/SHR in one EXEC cycle.
// Optional iterative shift-add MUL is compiled in only when ALU_MUL_EN is defined.
module alu_exec #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   exec_res;

    // Single-cycle ops; the top bit carries carry/borrow/shifted-out bit.
    function automatic logic [WIDTH:0] alu_eval(input logic [2:0] f_op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        case (f_op)
            3'b000:  return {1'b0, x} + {1'b0, y};
            3'b001:  return {1'b0, x} - {1'b0, y};
            3'b010:  return {1'b0, x & y};
            3'b011:  return {1'b0, x | y};
            3'b100:  return {1'b0, x ^ y};
            3'b101:  return {x, 1'b0};
            3'b110:  return {x[0], 1'b0, x[WIDTH-1:1]};
            default: return '0;
        endcase
    endfunction

    assign accept   = (state == IDLE) && start;
    assign exec_res = alu_eval(op_q, a_q, b_q);

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               mul_last;

    assign acc_nxt  = mplier[0] ? (acc + mcand) : acc;
    assign mul_last = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == MUL) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Multiplier consumes one bit of b per edge, LSB first.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (state == MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef ALU_MUL_EN
                    state_nxt = (op == 3'b111) ? MUL : EXEC;
`else
                    state_nxt = EXEC;
`endif
                end
            end
            EXEC: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            MUL: begin
                busy = 1'b1;
`ifdef ALU_MUL_EN
                if (mul_last) state_nxt = DONE;
`else
                state_nxt = IDLE;
`endif
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs change only on the completing edge and hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
        end else if (state == EXEC) begin
            result <= exec_res[WIDTH-1:0];
            carry  <= exec_res[WIDTH];
            zero   <= (exec_res[WIDTH-1:0] == '0);
`ifdef ALU_MUL_EN
        end else if ((state == MUL) && mul_last) begin
            result <= acc_nxt[WIDTH-1:0];
            carry  <= |acc_nxt[2*WIDTH-1:WIDTH];
            zero   <= (acc_nxt[WIDTH-1:0] == '0);
`endif
        end
    end

endmodule
